dmem_bus_bridge: RTL
====================

Name: dmem_bus_bridge

Overview:
- Sits directly downstream of the control unit. It consumes daddr, dwe and dwdata, plus a load-request strobe from the decoder, and returns drdata.
- Converts each single-cycle DMEM access into a valid/ready request plus a response transaction on the data bus.
- Asserts stall so the CPU holds PC and register writes until the access completes.
- Adds a response timeout with a sticky error flag so the core can never hang forever on a dead bus.

Parameters:
- TIMEOUT, 64, number of cycles spent in REQ+WAIT_RSP before the access is aborted. Must be >= 2.
- CNT_W, 7, counter width; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- dre  in  1  load access this instruction (decoder: op[5:3]==3'b010)
- dwe  in  4  byte write enables from control
- daddr  in  32  byte address from control
- dwdata  in  32  lane-aligned store data from control
- drdata  out  32  read word to control; lane selection is done by control
- stall  out  1  hold PC and suppress rwe while high
- bus_req_valid  out  1  request valid
- bus_req_ready  in  1  bus accepts the request
- bus_addr  out  32  word address, {daddr[31:2],2'b00}
- bus_we  out  4  byte enables; 0 = read
- bus_wdata  out  32  write data
- bus_rsp_valid  in  1  response valid (reads and writes both respond)
- bus_rdata  in  32  response data
- err  out  1  sticky timeout flag

Behaviour:
- Reset (async, reset low) forces:
  - state IDLE, counter 0, err 0, drdata 0.
  - bus_req_valid 0, bus_addr 0, bus_we 0, bus_wdata 0.
  - stall is combinational and evaluates to 0 while reset is low.
- access = dre | (|dwe). If dwe is nonzero and dre is 1, the access is a write and dre is ignored.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
  - IDLE: when access is high, latch bus_addr, bus_we (dwe, or 0 for a load) and bus_wdata, then go to REQ. Otherwise stay in IDLE.
  - REQ: bus_req_valid=1. When bus_req_ready is high, go to WAIT_RSP. Addr, we and wdata stay stable while valid is high and ready is low.
  - WAIT_RSP: when bus_rsp_valid is high, register drdata<=bus_rdata (write responses also load it; control ignores the value), then go to DONE.
  - DONE: for one cycle, drdata holds the response and stall=0, so the CPU commits this instruction. Then go to IDLE unconditionally; the next instruction is only sampled in IDLE.
- stall = (IDLE & access) | REQ | WAIT_RSP. The minimum access costs 3 stall cycles plus the DONE cycle when ready and rsp each arrive one cycle after the request.
- Same-cycle ready and rsp:
  - A response cannot arrive in the same cycle as its own ready.
  - bus_rsp_valid seen in REQ is ignored.
- Timeout:
  - The counter clears on IDLE->REQ and increments every cycle in REQ or WAIT_RSP.
  - When counter == TIMEOUT-1 and no handshake completes in that cycle: go to DONE, set drdata=0, set err=1.
  - In REQ, bus_req_valid drops in the DONE cycle.
  - A late bus_rsp_valid arriving in DONE or IDLE is discarded.
- err stays set until reset. It does not block further accesses.
- bus_rsp_valid in IDLE with no outstanding request is ignored.
- Reset mid-transaction: immediate return to IDLE, valid drops asynchronously, and no response is awaited.

Decomposition:
- Shared cpu_pkg: FSM state enum (2 bits), WORD_W=32, BE_W=4, the load-op decode constant 3'b010 used to derive dre, and the bus request/response struct typedefs.
- One natural sub-module: dmem_timeout_ctr, holding the counter with clear/enable/expire, parameterised by TIMEOUT and CNT_W.
- The FSM and datapath registers stay in dmem_bus_bridge.

Test Plan:
1. LW, daddr=0x104, dre=1, ready in cycle 1, rsp in cycle 2 with rdata=0xDEADBEEF -> bus_addr=0x104, bus_we=0, stall high for 3 cycles, DONE drdata=0xDEADBEEF, stall=0.
2. SB, daddr=0x203, dwe=4'b1000, dwdata=0xAB000000, ready held low for 5 cycles -> bus_addr=0x200, we and wdata stable throughout valid, single request, stall until DONE.
3. Back-to-back SW then LW -> two separate requests, IDLE visited between them, no re-issue of the SW during its DONE cycle.
4. Read with no rsp, TIMEOUT=8 -> DONE after 8 cycles in REQ+WAIT_RSP, drdata=0, err=1; a late rsp in IDLE is ignored; the next access completes normally with err still 1.
5. reset pulled low during WAIT_RSP -> valid 0, state IDLE, err 0; after release, a new load completes correctly.
6. dre=1 with dwe=4'b0011 -> treated as a write, bus_we=4'b0011.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core definitions used by the data-memory bus bridge.
//   - WORD_W / BE_W   : data word and byte-enable widths
//   - LOAD_OP         : op[5:3] decode that the decoder turns into dre
//   - dmem_state_e    : bridge FSM states
//   - bus_req_t       : request fields held stable while valid is up
//   - bus_rsp_t       : response fields returned by the data bus
package cpu_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic [2:0] LOAD_OP = 3'b010;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StWaitRsp = 2'd2,
        StDone    = 2'd3
    } dmem_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic [BE_W-1:0]   we;
        logic [WORD_W-1:0] wdata;
    } bus_req_t;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] rdata;
    } bus_rsp_t;

    // Decoder helper: true when op[5:3] selects a load.
    function automatic logic is_load(input logic [2:0] op);
        return op == LOAD_OP;
    endfunction

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Response timeout counter for the DMEM bus bridge.
//   clk_i     : core clock
//   rst_ni    : asynchronous active-low reset
//   clr_i     : restart the count (new access issued)
//   en_i      : count this cycle (access outstanding)
//   expired_o : the current cycle is the last one allowed before abort
module dmem_timeout_ctr #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SatCnt  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating at TIMEOUT: a handshake landing on the last REQ cycle can push
    // the count one past LastCnt, and expiry must still fire in WAIT_RSP.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != SatCnt)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q >= LastCnt);

endmodule

// File: rtl/dmem_bus_bridge.sv
// Turns single-cycle DMEM accesses from the control unit into a valid/ready
// request plus response on the data bus, stalling the core until done.
//   clk, reset (async, active-low)
//   dre, dwe, daddr, dwdata : access from decoder/control (write wins over dre)
//   drdata                  : response word, valid in the DONE cycle
//   stall                   : hold PC and suppress register writes
//   bus_req_valid/ready, bus_addr, bus_we, bus_wdata : request channel
//   bus_rsp_valid, bus_rdata                         : response channel
//   err                     : sticky response-timeout flag
module dmem_bus_bridge
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dre,
    input  logic [BE_W-1:0]   dwe,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dwdata,
    output logic [WORD_W-1:0] drdata,
    output logic              stall,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [WORD_W-1:0] bus_addr,
    output logic [BE_W-1:0]   bus_we,
    output logic [WORD_W-1:0] bus_wdata,
    input  logic              bus_rsp_valid,
    input  logic [WORD_W-1:0] bus_rdata,
    output logic              err
);

    dmem_state_e       state_q, state_d;
    bus_req_t          req_q, req_d;
    logic [WORD_W-1:0] drdata_q, drdata_d;
    logic              err_q, err_d;

    logic is_write;
    logic access;
    logic ctr_clr;
    logic ctr_en;
    logic expired;

    assign is_write = |dwe;
    assign access   = dre | is_write;

    dmem_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout_ctr (
        .clk_i     (clk),
        .rst_ni    (reset),
        .clr_i     (ctr_clr),
        .en_i      (ctr_en),
        .expired_o (expired)
    );

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        drdata_d = drdata_q;
        err_d    = err_q;
        ctr_clr  = 1'b0;
        ctr_en   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (access) begin
                    req_d.addr  = {daddr[WORD_W-1:2], 2'b00};
                    req_d.we    = is_write ? dwe : '0;
                    req_d.wdata = dwdata;
                    ctr_clr     = 1'b1;
                    state_d     = StReq;
                end
            end
            StReq: begin
                ctr_en = 1'b1;
                // A response in REQ cannot belong to this request; ignore it.
                if (bus_req_ready) begin
                    state_d = StWaitRsp;
                end else if (expired) begin
                    drdata_d = '0;
                    err_d    = 1'b1;
                    state_d  = StDone;
                end
            end
            StWaitRsp: begin
                ctr_en = 1'b1;
                if (bus_rsp_valid) begin
                    drdata_d = bus_rdata;
                    state_d  = StDone;
                end else if (expired) begin
                    drdata_d = '0;
                    err_d    = 1'b1;
                    state_d  = StDone;
                end
            end
            StDone: begin
                // Core commits this cycle; new access is only sampled in IDLE.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            req_q    <= '0;
            drdata_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            drdata_q <= drdata_d;
            err_q    <= err_d;
        end
    end

    // Valid follows the state register, so an async reset drops it at once.
    assign bus_req_valid = (state_q == StReq);
    assign bus_addr      = req_q.addr;
    assign bus_we        = req_q.we;
    assign bus_wdata     = req_q.wdata;
    assign drdata        = drdata_q;
    assign err           = err_q;

    assign stall = reset & (((state_q == StIdle) & access) |
                            (state_q == StReq) |
                            (state_q == StWaitRsp));

endmodule
